// File: rtl/gp_apb_axis_pkg.sv
// Shared types for the APB-completer to AXI-Stream request/response bridge.
// Holds the FSM state encoding and the fixed-width tuser fields.
package gp_apb_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // fwd tuser carries {pwrite, paddr}; bwd tuser carries only the error flag
  localparam int unsigned FWD_TUSER_WRITE_W = 1;
  localparam int unsigned BWD_TUSER_W       = 1;

endpackage

// File: rtl/gp_apb_to_axis_bridge.sv
// APB completer: each APB transfer becomes one fwd request beat, completed by one bwd response beat.
// An optional timeout ends the access with PSLVERR; late responses are then drained and discarded.
module gp_apb_to_axis_bridge
  import gp_apb_axis_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_USER_WIDTH = APB_ADDR_WIDTH + FWD_TUSER_WRITE_W,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned STALE_WIDTH    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [AXI_DATA_WIDTH-1:0] fwd_tdata_o,
  output logic [AXI_USER_WIDTH-1:0] fwd_tuser_o,
  output logic                      fwd_tvalid_o,
  input  logic                      fwd_tready_i,
  input  logic [AXI_DATA_WIDTH-1:0] bwd_tdata_i,
  input  logic [BWD_TUSER_W-1:0]    bwd_tuser_i,
  input  logic                      bwd_tvalid_i,
  output logic                      bwd_tready_o
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [STALE_WIDTH-1:0] STALE_MAX = '1;

  state_e                    state_q, state_d;
  logic                      fwd_tvalid_q;
  logic [AXI_DATA_WIDTH-1:0] fwd_tdata_q;
  logic [AXI_USER_WIDTH-1:0] fwd_tuser_q;
  logic [APB_DATA_WIDTH-1:0] prdata_q;
  logic                      pslverr_q;
  logic [TO_W-1:0]           to_cnt_q;
  logic [STALE_WIDTH-1:0]    stale_q;
  logic                      setup_wait_q;

  logic capture, rsp_done, to_done, stale_inc;
  logic fwd_hs, bwd_hs, stale_hs, rsp_hs, to_en, to_hit;

  assign pready_o     = (state_q == DONE);
  assign bwd_tready_o = (state_q == RSP) | (stale_q != '0);
  assign fwd_tvalid_o = fwd_tvalid_q;
  assign fwd_tdata_o  = fwd_tdata_q;
  assign fwd_tuser_o  = fwd_tuser_q;
  assign prdata_o     = prdata_q;
  assign pslverr_o    = pslverr_q;

  assign fwd_hs   = fwd_tvalid_q & fwd_tready_i;
  assign bwd_hs   = bwd_tready_o & bwd_tvalid_i;
  assign stale_hs = bwd_hs & (stale_q != '0);
  assign rsp_hs   = bwd_hs & (state_q == RSP) & (stale_q == '0);
  // A saturated stale counter means no room to track another abandoned response
  assign to_en    = (TIMEOUT_CYCLES != 0) && (stale_q != STALE_MAX);
  assign to_hit   = to_en && (to_cnt_q == TO_W'(TO_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    to_done   = 1'b0;
    // a request abandoned by a REQ timeout still owes a response once it handshakes
    stale_inc = fwd_hs & (state_q != REQ);
    case (state_q)
      IDLE: begin
        // a SETUP blocked by an abandoned request is accepted later even though it is now in ACCESS
        if (psel_i & (~penable_i | setup_wait_q) & ~fwd_tvalid_q) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fwd_hs) begin
          state_d = RSP;
        end else if (to_hit) begin
          to_done = 1'b1;
          state_d = DONE;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          rsp_done = 1'b1;
          state_d  = DONE;
        end else if (to_hit) begin
          to_done   = 1'b1;
          stale_inc = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_tvalid_q <= 1'b0;
      fwd_tdata_q  <= '0;
      fwd_tuser_q  <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      to_cnt_q     <= '0;
      stale_q      <= '0;
      setup_wait_q <= 1'b0;
    end else begin
      if (capture) begin
        fwd_tvalid_q <= 1'b1;
        fwd_tdata_q  <= pwdata_i;
        fwd_tuser_q  <= AXI_USER_WIDTH'({pwrite_i, paddr_i});
      end else if (fwd_hs) begin
        fwd_tvalid_q <= 1'b0;
      end

      if (rsp_done) begin
        prdata_q  <= bwd_tdata_i;
        pslverr_q <= bwd_tuser_i[0];
      end else if (to_done) begin
        prdata_q  <= '0;
        pslverr_q <= 1'b1;
      end

      // saturating at the last count keeps an expired budget expired while the timeout is disabled
      if (capture)
        to_cnt_q <= '0;
      else if (((state_q == REQ) || (state_q == RSP)) && (to_cnt_q != TO_W'(TO_LAST)))
        to_cnt_q <= to_cnt_q + TO_W'(1);

      case ({stale_inc, stale_hs})
        2'b10:   stale_q <= stale_q + STALE_WIDTH'(1);
        2'b01:   stale_q <= stale_q - STALE_WIDTH'(1);
        default: stale_q <= stale_q;
      endcase

      if (capture | ~psel_i)
        setup_wait_q <= 1'b0;
      else if ((state_q == IDLE) & ~penable_i & fwd_tvalid_q)
        setup_wait_q <= 1'b1;
    end
  end

endmodule
